multiciclo_control: RTL

// - Moore FSM sequencing the multicycle MIPS datapath: one shared memory, IR, A/B/ALUOut regs.
// - Decodes opcode from IR, drives every datapath mux/enable per cycle; waits on memory handshake.
// - Sits beside the datapath inside the multicycle top; its role matches the control unit of the single-cycle core.

---
 rtl/multiciclo_control_if.sv | 44 ++++
 rtl/multiciclo_control.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multiciclo_control_if.sv
// -----------------------------------------------------------------------------
// multiciclo_control_if
// Bundles the signals between the multicycle control FSM and the datapath.
//   Op, mem_ready      : datapath -> control (opcode from IR, memory done)
//   PCWrite..PCSrc     : control -> datapath (enables and mux selects)
//   state_o            : current FSM state, for debug and bench observation
//   illegal_op         : one-cycle pulse on an undecodable opcode in DECODE
// Modports:
//   master : the control unit (drives the controls, samples Op/mem_ready)
//   slave  : the datapath side (drives Op/mem_ready, samples the controls)
// -----------------------------------------------------------------------------
interface multiciclo_control_if;
    logic [5:0] Op;
    logic       mem_ready;
    logic       PCWrite;
    logic       Branch;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic [3:0] state_o;
    logic       illegal_op;

    modport master (
        input  Op, mem_ready,
        output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, state_o,
               illegal_op
    );

    modport slave (
        output Op, mem_ready,
        input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, state_o,
               illegal_op
    );
endinterface

// File: rtl/multiciclo_control.sv
// -----------------------------------------------------------------------------
// multiciclo_control
// Moore FSM sequencing the multicycle MIPS datapath (shared memory, IR, A/B and
// ALUOut registers). Decodes the opcode held in IR and drives every datapath
// enable and mux select each cycle, stalling on the memory handshake.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high; forces FETCH and quiets enables
//   bus  : multiciclo_control_if.master (Op, mem_ready in; controls out)
//
// Build option:
//   MC_ADDI_EN : when defined, ADDI is executed through ADDIEX/ADDIWB.
//                When undefined, ADDI decodes as an illegal opcode and the
//                ADDI state codes behave like the other unreachable codes.
// -----------------------------------------------------------------------------
module multiciclo_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic                 clk,
    input  logic                 rst,
    multiciclo_control_if.master bus
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
`ifdef MC_ADDI_EN
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
`endif
    localparam logic [3:0] S_JUMP   = 4'd11;

    logic [3:0] state;
    logic [3:0] next_state;

    // Combinational control values before reset gating
    logic       c_pcwrite, c_branch, c_iord, c_memread, c_memwrite, c_irwrite;
    logic       c_regdst, c_memtoreg, c_regwrite, c_alusrca, c_illegal;
    logic [1:0] c_alusrcb, c_aluop, c_pcsrc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      next_state = S_ADDIEX;
`else
                    OP_ADDI:      next_state = S_FETCH;
`endif
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.Op == OP_LW)
                    next_state = S_MEMRD;
                else if (bus.Op == OP_SW)
                    next_state = S_MEMWR;
                else
                    next_state = S_FETCH;
            end
            S_MEMRD:  next_state = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  next_state = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   next_state = S_ALUWB;
            S_ALUWB:  next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDIEX: next_state = S_ADDIWB;
            S_ADDIWB: next_state = S_FETCH;
`endif
            S_JUMP:   next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore; illegal_op additionally looks at Op)
    // ------------------------------------------------------------------
    always_comb begin
        c_pcwrite  = 1'b0;
        c_branch   = 1'b0;
        c_iord     = 1'b0;
        c_memread  = 1'b0;
        c_memwrite = 1'b0;
        c_irwrite  = 1'b0;
        c_regdst   = 1'b0;
        c_memtoreg = 1'b0;
        c_regwrite = 1'b0;
        c_alusrca  = 1'b0;
        c_alusrcb  = 2'b00;
        c_aluop    = 2'b00;
        c_pcsrc    = 2'b00;
        c_illegal  = 1'b0;
        case (state)
            S_DECODE: begin
                // Precompute branch target into ALUOut while decoding
                c_alusrcb = 2'b11;
                case (bus.Op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: c_illegal = 1'b0;
`ifdef MC_ADDI_EN
                    OP_ADDI: c_illegal = 1'b0;
`endif
                    default: c_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                c_alusrca = 1'b1;
                c_alusrcb = 2'b10;
            end
            S_MEMRD: begin
                c_iord    = 1'b1;
                c_memread = 1'b1;
            end
            S_MEMWB: begin
                c_memtoreg = 1'b1;
                c_regwrite = 1'b1;
            end
            S_MEMWR: begin
                c_iord     = 1'b1;
                c_memwrite = 1'b1;
            end
            S_EXEC: begin
                c_alusrca = 1'b1;
                c_aluop   = 2'b10;
            end
            S_ALUWB: begin
                c_regdst   = 1'b1;
                c_regwrite = 1'b1;
            end
            S_BRANCH: begin
                c_alusrca = 1'b1;
                c_aluop   = 2'b01;
                c_pcsrc   = 2'b01;
                c_branch  = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                c_alusrca = 1'b1;
                c_alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                c_regwrite = 1'b1;
            end
`endif
            S_JUMP: begin
                c_pcsrc   = 2'b10;
                c_pcwrite = 1'b1;
            end
            default: begin
                // FETCH and every unreachable code: read instruction, PC+4.
                // PC only advances on the cycle the read completes.
                c_memread = 1'b1;
                c_irwrite = 1'b1;
                c_alusrcb = 2'b01;
                c_pcwrite = bus.mem_ready;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Reset gating: while rst is high the enables drop in the same
    // timestep (abandoning any memory access) and selects sit at FETCH.
    // ------------------------------------------------------------------
    always_comb begin
        bus.PCWrite    = c_pcwrite  & ~rst;
        bus.Branch     = c_branch   & ~rst;
        bus.MemRead    = c_memread  & ~rst;
        bus.MemWrite   = c_memwrite & ~rst;
        bus.IRWrite    = c_irwrite  & ~rst;
        bus.RegWrite   = c_regwrite & ~rst;
        bus.illegal_op = c_illegal  & ~rst;
        bus.IorD       = rst ? 1'b0  : c_iord;
        bus.RegDst     = rst ? 1'b0  : c_regdst;
        bus.MemtoReg   = rst ? 1'b0  : c_memtoreg;
        bus.ALUSrcA    = rst ? 1'b0  : c_alusrca;
        bus.ALUSrcB    = rst ? 2'b01 : c_alusrcb;
        bus.ALUOp      = rst ? 2'b00 : c_aluop;
        bus.PCSrc      = rst ? 2'b00 : c_pcsrc;
        bus.state_o    = rst ? S_FETCH : state;
    end

endmodule
